vga_plot_arbiter: RTL and testbench

//   Shares the single plot port of the 160x120, 3-bit-colour VGA adapter between NUM_REQ pixel producers.

---
 rtl/doom58_vga_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/vga_plot_arbiter.sv | 157 +++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/doom58_vga_pkg.sv
// Shared widths, default screen geometry, palette and FSM state type for the
// VGA plot path.
package doom58_vga_pkg;

    localparam int SCR_W_DEF = 160;
    localparam int SCR_H_DEF = 120;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int COL_W = 3;

    localparam logic [COL_W-1:0] BLACK   = 3'b000;
    localparam logic [COL_W-1:0] BLUE    = 3'b001;
    localparam logic [COL_W-1:0] GREEN   = 3'b010;
    localparam logic [COL_W-1:0] CYAN    = 3'b011;
    localparam logic [COL_W-1:0] RED     = 3'b100;
    localparam logic [COL_W-1:0] MAGENTA = 3'b101;
    localparam logic [COL_W-1:0] YELLOW  = 3'b110;
    localparam logic [COL_W-1:0] WHITE   = 3'b111;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } plot_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request after ptr,
// wrapping modulo NUM_REQ, wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic found;
    int   cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA adapter plot port between NUM_REQ pixel producers, with a
// built-in full-screen clear engine and out-of-range pixel filtering.
//
//   state | meaning
//   ARB   | round-robin grants to requesters; clear_start preempts
//   CLEAR | raster fill of the whole screen, requesters stalled
module vga_plot_arbiter
    import doom58_vga_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SCR_W   = SCR_W_DEF,
    parameter int SCR_H   = SCR_H_DEF
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [X_W*NUM_REQ-1:0]   req_x,
    input  logic [Y_W*NUM_REQ-1:0]   req_y,
    input  logic [COL_W*NUM_REQ-1:0] req_colour,
    input  logic                     clear_start,
    input  logic [COL_W-1:0]         clear_colour,
    output logic                     clear_busy,
    output logic                     clear_done,
    output logic [15:0]              drop_count,
    output logic [X_W-1:0]           vga_x,
    output logic [Y_W-1:0]           vga_y,
    output logic [COL_W-1:0]         vga_colour,
    output logic                     vga_write
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [X_W-1:0] X_LAST = X_W'(SCR_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCR_H - 1);

    plot_state_e      state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [X_W-1:0]   cx_q;
    logic [Y_W-1:0]   cy_q;
    logic [COL_W-1:0] fill_q;
    logic [X_W-1:0]   vga_x_q;
    logic [Y_W-1:0]   vga_y_q;
    logic [COL_W-1:0] vga_colour_q;
    logic             vga_write_q;
    logic             clear_busy_q;
    logic             clear_done_q;
    logic [15:0]      drop_q;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               arb_en;
    logic               xfer;
    logic               in_range;
    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [COL_W-1:0]   sel_colour;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Nothing is accepted while reset is held, so ready is masked by resetn too.
    assign arb_en    = resetn && (state_q == ARB) && !clear_start;
    assign req_ready = arb_en ? grant : '0;
    assign xfer      = |req_ready;

    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_x      = req_x[X_W*k +: X_W];
                sel_y      = req_y[Y_W*k +: Y_W];
                sel_colour = req_colour[COL_W*k +: COL_W];
            end
        end
    end

    assign in_range = (sel_x <= X_LAST) && (sel_y <= Y_LAST);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= ARB;
            ptr_q        <= IDX_W'(NUM_REQ - 1);
            cx_q         <= '0;
            cy_q         <= '0;
            fill_q       <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_write_q  <= 1'b0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
            drop_q       <= '0;
        end else begin
            vga_write_q  <= 1'b0;
            clear_done_q <= 1'b0;
            case (state_q)
                ARB: begin
                    if (clear_start) begin
                        state_q      <= CLEAR;
                        fill_q       <= clear_colour;
                        cx_q         <= '0;
                        cy_q         <= '0;
                        clear_busy_q <= 1'b1;
                    end else if (xfer) begin
                        ptr_q <= grant_idx;
                        if (in_range) begin
                            vga_x_q      <= sel_x;
                            vga_y_q      <= sel_y;
                            vga_colour_q <= sel_colour;
                            vga_write_q  <= 1'b1;
                        end else if (drop_q != 16'hFFFF) begin
                            drop_q <= drop_q + 16'd1;
                        end
                    end
                end
                CLEAR: begin
                    vga_x_q      <= cx_q;
                    vga_y_q      <= cy_q;
                    vga_colour_q <= fill_q;
                    vga_write_q  <= 1'b1;
                    if (cx_q == X_LAST) begin
                        cx_q <= '0;
                        if (cy_q == Y_LAST) begin
                            cy_q         <= '0;
                            state_q      <= ARB;
                            clear_busy_q <= 1'b0;
                            clear_done_q <= 1'b1;
                        end else begin
                            cy_q <= cy_q + Y_W'(1);
                        end
                    end else begin
                        cx_q <= cx_q + X_W'(1);
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_write  = vga_write_q;
    assign clear_busy = clear_busy_q;
    assign clear_done = clear_done_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench: directed vector table, randomized traffic against a
// behavioural model, and the clear-engine corner sequences.
module tb_vga_plot_arbiter;

    localparam int N  = 4;
    localparam int SW = 160;
    localparam int SH = 120;

    logic            clock = 1'b0;
    logic            resetn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [8*N-1:0]  req_x;
    logic [7*N-1:0]  req_y;
    logic [3*N-1:0]  req_colour;
    logic            clear_start;
    logic [2:0]      clear_colour;
    logic            clear_busy;
    logic            clear_done;
    logic [15:0]     drop_count;
    logic [7:0]      vga_x;
    logic [6:0]      vga_y;
    logic [2:0]      vga_colour;
    logic            vga_write;

    always #5 clock = ~clock;

    vga_plot_arbiter #(.NUM_REQ(N), .SCR_W(SW), .SCR_H(SH)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_colour   (req_colour),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .drop_count   (drop_count),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_write    (vga_write)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] x;
        logic [27:0] y;
        logic [11:0] c;
        logic [3:0]  rdy;
        logic        wr;
        logic [7:0]  ex;
        logic [6:0]  ey;
        logic [2:0]  ec;
        logic [15:0] drop;
    } vec_t;

    vec_t tbl[12];

    // Behavioural model: last granted index, pending pixel per requester, output view.
    int         m_last;
    int         m_drop;
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_c;
    int         pv[N];
    int         px[N];
    int         py[N];
    int         pc[N];

    task automatic drive_pend();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = (pv[i] != 0);
            req_x[8*i +: 8]      = 8'(px[i]);
            req_y[7*i +: 7]      = 7'(py[i]);
            req_colour[3*i +: 3] = 3'(pc[i]);
        end
    endtask

    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            if (pv[(m_last + k) % N] != 0) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic new_pixels(input int chance);
        for (int i = 0; i < N; i++) begin
            if (pv[i] == 0 && $urandom_range(0, 99) < chance) begin
                pv[i] = 1;
                if ($urandom_range(0, 4) == 0) begin
                    px[i] = $urandom_range(0, 175);
                    py[i] = $urandom_range(0, 127);
                end else begin
                    px[i] = $urandom_range(0, SW - 1);
                    py[i] = $urandom_range(0, SH - 1);
                end
                pc[i] = $urandom_range(0, 7);
            end
        end
    endtask

    task automatic model_cycle();
        int         g;
        logic [3:0] er;
        logic       ew;
        g  = pick();
        er = (g >= 0) ? 4'(1 << g) : 4'd0;
        #1;
        chk("rr_ready", 32'(req_ready), 32'(er));
        @(posedge clock);
        #1;
        ew = 1'b0;
        if (g >= 0) begin
            m_last = g;
            if (px[g] < SW && py[g] < SH) begin
                ew  = 1'b1;
                m_x = 8'(px[g]);
                m_y = 7'(py[g]);
                m_c = 3'(pc[g]);
            end else if (m_drop < 65535) begin
                m_drop++;
            end
            pv[g] = 0;
        end
        chk("rr_write", 32'(vga_write), 32'(ew));
        chk("rr_x", 32'(vga_x), 32'(m_x));
        chk("rr_y", 32'(vga_y), 32'(m_y));
        chk("rr_colour", 32'(vga_colour), 32'(m_c));
        chk("rr_drop", 32'(drop_count), 32'(m_drop));
    endtask

    initial begin
        int n;
        int bad;
        int cyc;
        int done_seen;
        int g;

        for (int k = 0; k < 8; k++) begin
            g = k % 4;
            tbl[k] = '{4'hF, {8'd13, 8'd12, 8'd11, 8'd10}, {7'd23, 7'd22, 7'd21, 7'd20},
                       {3'd4, 3'd3, 3'd2, 3'd1}, 4'(1 << g), 1'b1, 8'(10 + g), 7'(20 + g),
                       3'(g + 1), 16'd0};
        end
        tbl[8]  = '{4'b0100, {8'd0, 8'd159, 8'd0, 8'd0}, {7'd0, 7'd119, 7'd0, 7'd0},
                    {3'd0, 3'd5, 3'd0, 3'd0}, 4'b0100, 1'b1, 8'd159, 7'd119, 3'd5, 16'd0};
        tbl[9]  = '{4'b0010, {8'd0, 8'd0, 8'd160, 8'd0}, {7'd0, 7'd0, 7'd10, 7'd0},
                    {3'd0, 3'd0, 3'd7, 3'd0}, 4'b0010, 1'b0, 8'd159, 7'd119, 3'd5, 16'd1};
        tbl[10] = '{4'b0010, {8'd0, 8'd0, 8'd5, 8'd0}, {7'd0, 7'd0, 7'd120, 7'd0},
                    {3'd0, 3'd0, 3'd6, 3'd0}, 4'b0010, 1'b0, 8'd159, 7'd119, 3'd5, 16'd2};
        tbl[11] = '{4'b0000, 32'd0, 28'd0, 12'd0, 4'b0000, 1'b0, 8'd159, 7'd119, 3'd5, 16'd2};

        // Reset with every requester asserting valid.
        resetn       = 1'b0;
        req_valid    = '1;
        req_x        = '0;
        req_y        = '0;
        req_colour   = '0;
        clear_start  = 1'b0;
        clear_colour = 3'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_write", 32'(vga_write), 32'd0);
        chk("rst_x", 32'(vga_x), 32'd0);
        chk("rst_y", 32'(vga_y), 32'd0);
        chk("rst_colour", 32'(vga_colour), 32'd0);
        chk("rst_busy", 32'(clear_busy), 32'd0);
        chk("rst_done", 32'(clear_done), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        resetn = 1'b1;

        for (int r = 0; r < 12; r++) begin
            req_valid  = tbl[r].valid;
            req_x      = tbl[r].x;
            req_y      = tbl[r].y;
            req_colour = tbl[r].c;
            #1;
            chk($sformatf("tbl%0d_ready", r), 32'(req_ready), 32'(tbl[r].rdy));
            @(posedge clock);
            #1;
            chk($sformatf("tbl%0d_write", r), 32'(vga_write), 32'(tbl[r].wr));
            chk($sformatf("tbl%0d_x", r), 32'(vga_x), 32'(tbl[r].ex));
            chk($sformatf("tbl%0d_y", r), 32'(vga_y), 32'(tbl[r].ey));
            chk($sformatf("tbl%0d_colour", r), 32'(vga_colour), 32'(tbl[r].ec));
            chk($sformatf("tbl%0d_drop", r), 32'(drop_count), 32'(tbl[r].drop));
        end

        m_last = 1;
        m_drop = 2;
        m_x    = 8'd159;
        m_y    = 7'd119;
        m_c    = 3'd5;
        for (int i = 0; i < N; i++) begin
            pv[i] = 0; px[i] = 0; py[i] = 0; pc[i] = 0;
        end

        for (int t = 0; t < 400; t++) begin
            new_pixels(40);
            drive_pend();
            model_cycle();
        end

        // Full-screen clear while all requesters hold pixels.
        new_pixels(100);
        drive_pend();
        clear_start  = 1'b1;
        clear_colour = 3'b001;
        #1;
        chk("clr_start_ready", 32'(req_ready), 32'd0);
        @(posedge clock);
        #1;
        clear_start = 1'b0;
        chk("clr_busy_first", 32'(clear_busy), 32'd1);
        n = 0; bad = 0; cyc = 0; done_seen = 0;
        while (done_seen == 0 && cyc < 19400) begin
            if (clear_busy && req_ready != 0) bad++;
            if (vga_write) begin
                if (vga_x != 8'(n % SW) || vga_y != 7'(n / SW) || vga_colour != 3'b001) bad++;
                n++;
            end
            if (clear_done) begin
                done_seen = 1;
            end else begin
                @(posedge clock);
                #1;
                cyc++;
            end
        end
        chk("clr_done_seen", 32'(done_seen), 32'd1);
        chk("clr_write_total", 32'(n), 32'(SW * SH));
        chk("clr_pixel_errors", 32'(bad), 32'd0);
        chk("clr_busy_at_done", 32'(clear_busy), 32'd0);
        chk("clr_last_x", 32'(vga_x), 32'd159);
        chk("clr_last_y", 32'(vga_y), 32'd119);
        m_x = 8'd159;
        m_y = 7'd119;
        m_c = 3'b001;
        model_cycle();
        chk("clr_done_pulse", 32'(clear_done), 32'd0);
        for (int t = 0; t < 60; t++) begin
            new_pixels(50);
            drive_pend();
            model_cycle();
        end

        // Clear restarted mid-sweep (ignored), then reset mid-sweep.
        for (int i = 0; i < N; i++) pv[i] = 0;
        drive_pend();
        clear_start  = 1'b1;
        clear_colour = 3'b110;
        @(posedge clock);
        #1;
        clear_start = 1'b0;
        n = 0; bad = 0; cyc = 0;
        while (n < 1000 && cyc < 1200) begin
            clear_start = 1'b0;
            if (vga_write) begin
                if (vga_x != 8'(n % SW) || vga_y != 7'(n / SW) || vga_colour != 3'b110) bad++;
                n++;
                if (n == 500) clear_start = 1'b1;
            end
            if (!clear_busy || clear_done) bad++;
            @(posedge clock);
            #1;
            cyc++;
        end
        clear_start = 1'b0;
        chk("mid_writes", 32'(n), 32'd1000);
        chk("mid_pixel_errors", 32'(bad), 32'd0);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        chk("mid_rst_write", 32'(vga_write), 32'd0);
        chk("mid_rst_busy", 32'(clear_busy), 32'd0);
        chk("mid_rst_drop", 32'(drop_count), 32'd0);
        resetn = 1'b1;
        bad = 0;
        for (int t = 0; t < 300; t++) begin
            @(posedge clock);
            #1;
            if (clear_done || vga_write || clear_busy) bad++;
        end
        chk("mid_rst_no_done", 32'(bad), 32'd0);

        m_last = N - 1;
        m_drop = 0;
        m_x    = 8'd0;
        m_y    = 7'd0;
        m_c    = 3'd0;
        for (int t = 0; t < 80; t++) begin
            new_pixels(50);
            drive_pend();
            model_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
